// File: rtl/deserializer_if.sv
// Chunk-stream input and rebuilt-frame output bundle for the deserializer.
// The master drives chunks and sees results; the slave is the deserializer itself.
interface deserializer_if #(
    parameter int unsigned PARALLEL_SIZE = 256,
    parameter int unsigned CHUNK_SIZE    = 16,
    parameter int unsigned INDEX_SIZE    = 4
);
    logic                             input_valid;
    logic [CHUNK_SIZE+INDEX_SIZE-1:0] input_data;
    logic                             output_valid;
    logic [PARALLEL_SIZE-1:0]         output_data;
    logic                             frame_error;
    logic                             busy;

    modport master (
        output input_valid, input_data,
        input  output_valid, output_data, frame_error, busy
    );

    modport slave (
        input  input_valid, input_data,
        output output_valid, output_data, frame_error, busy
    );
endinterface

// File: rtl/deserializer.sv
// Rebuilds a parallel frame from tagged serial chunks, flags tag sequence errors
// and resynchronises when a tag-0 chunk arrives out of order.
module deserializer #(
    parameter int unsigned PARALLEL_SIZE = 256,
    parameter int unsigned CHUNK_SIZE    = 16,
    parameter int unsigned WORD_SIZE     = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    deserializer_if.slave  bus
);
    localparam int unsigned NUM_CHUNKS      = PARALLEL_SIZE / CHUNK_SIZE;
    localparam int unsigned INDEX_SIZE      = $clog2(NUM_CHUNKS);
    localparam int unsigned CHUNKS_PER_WORD = WORD_SIZE / CHUNK_SIZE;
    localparam logic [INDEX_SIZE-1:0] LAST_K = INDEX_SIZE'(NUM_CHUNKS - 1);

    logic [INDEX_SIZE-1:0]    k_q, k_d;
    logic [PARALLEL_SIZE-1:0] asm_q, asm_d;
    logic [PARALLEL_SIZE-1:0] output_data_q, output_data_d;
    logic                     output_valid_q, output_valid_d;
    logic                     frame_error_q, frame_error_d;
    logic                     busy_q, busy_d;

    logic [INDEX_SIZE-1:0] tag;
    logic [CHUNK_SIZE-1:0] chunk;
    logic [INDEX_SIZE-1:0] exp_tag;
    logic                  wr_en;
    logic [INDEX_SIZE-1:0] wr_idx;

    assign tag     = bus.input_data[CHUNK_SIZE +: INDEX_SIZE];
    assign chunk   = bus.input_data[CHUNK_SIZE-1:0];
    assign exp_tag = INDEX_SIZE'(32'(k_q) / CHUNKS_PER_WORD);

    always_comb begin
        k_d            = k_q;
        asm_d          = asm_q;
        output_data_d  = output_data_q;
        output_valid_d = 1'b0;
        frame_error_d  = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = k_q;

        if (clear) begin
            k_d = '0;
        end else if (bus.input_valid) begin
            if (tag == exp_tag) begin
                wr_en = 1'b1;
                if (k_q == LAST_K) begin
                    k_d            = '0;
                    output_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end else begin
                frame_error_d = 1'b1;
                // A misplaced tag-0 chunk can only be the head of a new frame.
                if (tag == '0) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    k_d    = INDEX_SIZE'(1);
                end else begin
                    k_d = '0;
                end
            end
        end

        // Slot k: word k/CPW, first chunk of a word lands in its upper bits.
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (wr_en && (wr_idx == i[INDEX_SIZE-1:0])) begin
                asm_d[(i / CHUNKS_PER_WORD) * WORD_SIZE
                      + (CHUNKS_PER_WORD - 1 - (i % CHUNKS_PER_WORD)) * CHUNK_SIZE
                      +: CHUNK_SIZE] = chunk;
            end
        end

        if (output_valid_d) begin
            output_data_d = asm_d;
        end

        busy_d = (k_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q            <= '0;
            asm_q          <= '0;
            output_data_q  <= '0;
            output_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            k_q            <= k_d;
            asm_q          <= asm_d;
            output_data_q  <= output_data_d;
            output_valid_q <= output_valid_d;
            frame_error_q  <= frame_error_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.output_valid = output_valid_q;
    assign bus.output_data  = output_data_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for the deserializer: vector table plus hand-written
// frame sequences, with completed frames tracked through a scoreboard queue.
module tb_deserializer;
    typedef logic [255:0] frame_t;

    typedef struct {
        logic        v;
        logic [3:0]  tag;
        logic [15:0] d;
        logic        clr;
        logic        fe;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    deserializer_if #(.PARALLEL_SIZE(256), .CHUNK_SIZE(16), .INDEX_SIZE(4)) bus ();

    deserializer #(
        .PARALLEL_SIZE(256),
        .CHUNK_SIZE(16),
        .WORD_SIZE(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .bus  (bus)
    );

    frame_t sb_q[$];
    frame_t last_frame;
    int     ov_cycles[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;

    task automatic chk(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of input, then check outputs just after the edge.
    task automatic step(input logic v, input logic [3:0] tag, input logic [15:0] d,
                        input logic clr, input logic exp_fe, input logic exp_busy,
                        input string name);
        frame_t e;
        bus.input_valid = v;
        bus.input_data  = {tag, d};
        clear           = clr;
        @(posedge clk);
        #1;
        cyc++;
        chk({name, " frame_error"}, frame_t'(bus.frame_error), frame_t'(exp_fe));
        chk({name, " busy"}, frame_t'(bus.busy), frame_t'(exp_busy));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({name, " output_valid"}, frame_t'(bus.output_valid), frame_t'(1'b1));
            chk({name, " output_data"}, bus.output_data, e);
            last_frame = e;
            ov_cycles.push_back(cyc);
        end else begin
            chk({name, " output_valid"}, frame_t'(bus.output_valid), frame_t'(1'b0));
            chk({name, " output_data held"}, bus.output_data, last_frame);
        end
    endtask

    // Send chunks lo..hi of frame f, starting with the DUT counter at lo.
    task automatic send_range(input frame_t f, input int lo, input int hi,
                              input int max_gap, input string name);
        logic [31:0] word;
        logic [15:0] d;
        int          gaps;
        for (int k = lo; k <= hi; k++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gaps; g++)
                step(1'b0, 4'($urandom), 16'($urandom), 1'b0, 1'b0, k != 0, {name, " gap"});
            word = f[(k / 2) * 32 +: 32];
            d    = (k % 2 == 0) ? word[31:16] : word[15:0];
            if (k == 15) sb_q.push_back(f);
            step(1'b1, 4'(k / 2), d, 1'b0, 1'b0, k != 15, $sformatf("%s k%0d", name, k));
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] tag, input logic [15:0] d,
                                input logic clr, input logic fe, input logic busy);
        vec_t r;
        r.v = v; r.tag = tag; r.d = d; r.clr = clr; r.fe = fe; r.busy = busy;
        return r;
    endfunction

    function automatic logic [15:0] chunk_of(input frame_t f, input int k);
        logic [31:0] word;
        word = f[(k / 2) * 32 +: 32];
        return (k % 2 == 0) ? word[31:16] : word[15:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        frame_t nom, alt, rnd_a, rnd_b, f2;
        vec_t   tbl[$];
        logic [3:0] w4;

        for (int w = 0; w < 8; w++) begin
            w4 = 4'(w);
            nom[w * 32 +: 32]   = {4'hA, w4, 8'h00, 4'h5, w4, 8'h00};
            rnd_a[w * 32 +: 32] = $urandom;
            rnd_b[w * 32 +: 32] = $urandom;
        end
        alt = ~nom;

        // Vector table: tag error, non-zero tag at k=0, clear with a chunk.
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'(k / 2), chunk_of(nom, k), 0, 0, 1));
        tbl.push_back(mk(1, 4'd3, chunk_of(nom, 4), 0, 1, 0));
        tbl.push_back(mk(0, 4'd0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'd5, 16'hDEAD, 0, 1, 0));
        for (int k = 0; k < 9; k++) tbl.push_back(mk(1, 4'(k / 2), chunk_of(nom, k), 0, 0, 1));
        tbl.push_back(mk(1, 4'd4, chunk_of(nom, 9), 1, 0, 0));
        tbl.push_back(mk(1, 4'd1, chunk_of(nom, 2), 0, 1, 0));
        tbl.push_back(mk(1, 4'd0, chunk_of(nom, 0), 0, 0, 1));
        tbl.push_back(mk(0, 4'd0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, 4'd0, 16'hBEEF, 1, 0, 0));

        // Reset with random activity on the inputs.
        reset = 1'b1;
        clear = 1'b0;
        bus.input_valid = 1'b0;
        bus.input_data  = '0;
        last_frame = '0;
        for (int i = 0; i < 4; i++) begin
            bus.input_valid = 1'($urandom);
            bus.input_data  = 20'($urandom);
            clear           = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset output_valid", frame_t'(bus.output_valid), '0);
            chk("reset frame_error", frame_t'(bus.frame_error), '0);
            chk("reset busy", frame_t'(bus.busy), '0);
            chk("reset output_data", bus.output_data, '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, "post-reset idle");

        send_range(nom, 0, 15, 0, "nominal");

        foreach (tbl[i])
            step(tbl[i].v, tbl[i].tag, tbl[i].d, tbl[i].clr, tbl[i].fe, tbl[i].busy,
                 $sformatf("vec%0d", i));

        send_range(alt, 0, 15, 0, "after-error");
        send_range(nom, 0, 15, 3, "gapped");

        // Resync on an out-of-order tag-0 chunk.
        f2 = nom;
        f2[31:16] = 16'h1234;
        send_range(nom, 0, 5, 0, "resync pre");
        step(1'b1, 4'd0, 16'h1234, 1'b0, 1'b1, 1'b1, "resync head");
        send_range(f2, 1, 15, 0, "resync");

        // Two frames with no gap between them.
        ov_cycles.delete();
        send_range(rnd_a, 0, 15, 0, "b2b first");
        send_range(rnd_b, 0, 15, 0, "b2b second");
        chk("b2b pulse count", frame_t'(ov_cycles.size()), frame_t'(2));
        if (ov_cycles.size() == 2)
            chk("b2b pulse spacing", frame_t'(ov_cycles[1] - ov_cycles[0]), frame_t'(16));

        // Asynchronous reset in the middle of a frame.
        send_range(nom, 0, 10, 0, "pre-reset");
        reset = 1'b1;
        #2;
        chk("mid reset output_valid", frame_t'(bus.output_valid), '0);
        chk("mid reset frame_error", frame_t'(bus.frame_error), '0);
        chk("mid reset busy", frame_t'(bus.busy), '0);
        chk("mid reset output_data", bus.output_data, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_frame = '0;
        send_range(alt, 0, 15, 1, "post-reset frame");
        step(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, "final idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
